// File: rtl/pixel_stream_source.sv
// Replays a host-loaded IMG_W x IMG_H frame in raster order, one pixel per cycle, first pixel the cycle after start.
// Optional ROW_GAP idle cycles after each row but the last; pause holds the stream without skipping or repeating pixels.
module pixel_stream_source #(
    parameter int DATA_W  = 8,
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int ROW_GAP = 0,
    parameter int ADDR_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              start_i,
    input  logic              pause_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] pixel_out_o,
    output logic              busy_o,
    output logic              frame_done_o
);
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int AW1   = ADDR_W + 1;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [AW1-1:0]   NPIX_A   = AW1'(NPIX);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [7:0]       GAP_LOAD = 8'(ROW_GAP);

    typedef enum logic [1:0] {IDLE, STREAM, GAP, DONE} state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [ADDR_W-1:0] addr_q, addr_d, cur_addr;
    logic [COL_W-1:0]  col_q, col_d, cur_col;
    logic [ROW_W-1:0]  row_q, row_d, cur_row;
    logic [7:0]        gap_q, gap_d;
    logic              row_end_q, row_end_d;
    logic              last_q, last_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] pixel_q, pixel_d;
    logic              start_frame, emit, at_row_end;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // row_end_q/last_q describe the pixel on the output this cycle, so the
    // decision to gap or finish is taken at the very next edge, regardless of pause.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: state_d = start_i ? STREAM : IDLE;
            STREAM: begin
                if (last_q) begin
                    state_d = DONE;
                end else if (row_end_q && (ROW_GAP > 0)) begin
                    state_d = GAP;
                end
            end
            GAP:     if (gap_q <= 8'd1) state_d = STREAM;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_frame = ((state_q == IDLE) || (state_q == DONE)) && start_i;
        cur_addr    = start_frame ? '0 : addr_q;
        cur_col     = start_frame ? '0 : col_q;
        cur_row     = start_frame ? '0 : row_q;
        emit        = (state_d == STREAM) && !pause_i;
        at_row_end  = (cur_col == COL_LAST);

        addr_d    = cur_addr;
        col_d     = cur_col;
        row_d     = cur_row;
        row_end_d = 1'b0;
        last_d    = 1'b0;
        if (emit) begin
            addr_d    = cur_addr + ADDR_W'(1);
            row_end_d = at_row_end;
            last_d    = at_row_end && (cur_row == ROW_LAST);
            if (at_row_end) begin
                col_d = '0;
                row_d = cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
            end
        end

        gap_d = gap_q;
        if ((state_q == STREAM) && (state_d == GAP)) begin
            gap_d = GAP_LOAD;
        end else if (state_q == GAP) begin
            gap_d = gap_q - 8'd1;
        end

        out_valid_d = emit;
        pixel_d     = emit ? mem[cur_addr] : pixel_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            gap_q       <= '0;
            row_end_q   <= 1'b0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            pixel_q     <= '0;
        end else begin
            addr_q      <= addr_d;
            col_q       <= col_d;
            row_q       <= row_d;
            gap_q       <= gap_d;
            row_end_q   <= row_end_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            pixel_q     <= pixel_d;
        end
    end

    // Frame RAM is never reset; the read above sees pre-write data on a collision.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && ({1'b0, wr_addr_i} < NPIX_A)) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign pixel_out_o  = pixel_q;
    assign busy_o       = (state_q == STREAM) || (state_q == GAP);
    assign frame_done_o = (state_q == DONE);

endmodule

// File: tb/tb_pixel_stream_source.sv
// Bench for pixel_stream_source: ROW_GAP=0 and ROW_GAP=2 instances driven in lockstep.
// Table vectors, hand-written corner sequences and a randomized run against a frame-level reference model.
module tb_pixel_stream_source;
    localparam int W = 8;
    localparam int H = 8;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst, wr_en, start, pause;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       ov [2];
    logic [7:0] px [2];
    logic       bz [2];
    logic       fd [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pixel_stream_source #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .ROW_GAP(0), .ADDR_W(7)) dut0 (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .start_i(start), .pause_i(pause), .out_valid_o(ov[0]), .pixel_out_o(px[0]),
        .busy_o(bz[0]), .frame_done_o(fd[0]));

    pixel_stream_source #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .ROW_GAP(2), .ADDR_W(7)) dut2 (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .start_i(start), .pause_i(pause), .out_valid_o(ov[1]), .pixel_out_o(px[1]),
        .busy_o(bz[1]), .frame_done_o(fd[1]));

    // Reference model: a frame is N pixels; after every full row except the
    // last, gapv idle cycles follow; a pause sampled outside a gap withholds one pixel.
    logic [7:0] mem_m [N];
    int         gapv  [2] = '{0, 2};
    bit         m_act [2];
    bit         m_val [2];
    bit         m_done[2];
    int         m_k   [2];
    int         m_g   [2];
    logic [7:0] m_pix [2];

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic try_emit(input int d);
        if (!pause) begin
            m_val[d] = 1'b1;
            m_pix[d] = mem_m[m_k[d]];
            m_k[d]++;
            if ((m_k[d] % W == 0) && (m_k[d] < N)) m_g[d] = gapv[d];
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_act[d] = 0; m_val[d] = 0; m_done[d] = 0;
                m_k[d] = 0; m_g[d] = 0; m_pix[d] = '0;
            end else begin
                m_val[d]  = 0;
                m_done[d] = 0;
                if (!m_act[d]) begin
                    if (start) begin
                        m_act[d] = 1; m_k[d] = 0; m_g[d] = 0;
                        try_emit(d);
                    end
                end else if (m_k[d] == N) begin
                    m_act[d]  = 0;
                    m_done[d] = 1;
                end else if (m_g[d] > 0) begin
                    m_g[d]--;
                end else begin
                    try_emit(d);
                end
            end
        end
        // Writes land after the read of the same edge.
        if (wr_en && (int'(wr_addr) < N)) mem_m[wr_addr[5:0]] = wr_data;
    endtask

    task automatic cyc(input bit s, input bit p);
        start = s;
        pause = p;
        @(posedge clk);
        model_edge();
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d out_valid", d), int'(ov[d]), int'(m_val[d]));
            check($sformatf("d%0d busy", d), int'(bz[d]), int'(m_act[d]));
            check($sformatf("d%0d frame_done", d), int'(fd[d]), int'(m_done[d]));
            if (m_val[d]) check($sformatf("d%0d pixel k=%0d", d, m_k[d] - 1),
                                int'($signed(px[d])), int'($signed(m_pix[d])));
        end
        wr_en = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
    endtask

    typedef struct {
        bit s;
        bit p;
        bit v;
        int pix;
        bit b;
        bit fdn;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [16];
        int first [2], last [2], done_c [2], nval [2];
        int fpx, lpx, seen, t;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; pause = 1'b0;
        for (int i = 0; i < N; i++) mem_m[i] = '0;

        // Reset state
        rst = 1'b1; cyc(1'b0, 1'b0);
        rst = 1'b1; cyc(1'b1, 1'b0);
        check("reset pixel d0", int'(px[0]), 0);
        check("reset pixel d2", int'(px[1]), 0);

        // Ramp frame mem[i] = i-32
        for (int i = 0; i < N; i++) begin
            wr_en = 1'b1; wr_addr = 7'(i); wr_data = 8'(i - 32);
            cyc(1'b0, 1'b0);
        end

        // Table: start, pause 3 cycles with pixel 10 next, start ignored mid-stream
        for (int i = 0; i < 10; i++) tbl[i] = '{(i == 0), 1'b0, 1'b1, i - 32, 1'b1, 1'b0};
        for (int i = 10; i < 13; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, -23, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, -22, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b1, -21, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b1, -20, 1'b1, 1'b0};
        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].s, tbl[i].p);
            check($sformatf("tbl[%0d] valid", i), int'(ov[0]), int'(tbl[i].v));
            check($sformatf("tbl[%0d] pixel", i), int'($signed(px[0])), tbl[i].pix);
            check($sformatf("tbl[%0d] busy", i), int'(bz[0]), int'(tbl[i].b));
            check($sformatf("tbl[%0d] done", i), int'(fd[0]), int'(tbl[i].fdn));
        end
        drain(120);

        // Frame timing for both gap settings
        for (int d = 0; d < 2; d++) begin first[d] = -1; last[d] = -1; done_c[d] = -1; nval[d] = 0; end
        t = 0;
        while (t < 200 && (done_c[0] < 0 || done_c[1] < 0)) begin
            cyc((t == 0), 1'b0);
            t++;
            for (int d = 0; d < 2; d++) begin
                if (ov[d]) begin
                    if (first[d] < 0) first[d] = t;
                    last[d] = t;
                    nval[d]++;
                end
                if (fd[d] && done_c[d] < 0) done_c[d] = t;
            end
        end
        check("gap0 first cycle", first[0], 1);
        check("gap0 last cycle", last[0], 64);
        check("gap0 done cycle", done_c[0], 65);
        check("gap0 valid count", nval[0], 64);
        check("gap2 first cycle", first[1], 1);
        check("gap2 last cycle", last[1], 78);
        check("gap2 done cycle", done_c[1], 79);
        check("gap2 valid count", nval[1], 64);
        drain(10);

        // Extreme values and an out-of-range write
        wr_en = 1'b1; wr_addr = 7'd0;  wr_data = 8'h80; cyc(1'b0, 1'b0);
        wr_en = 1'b1; wr_addr = 7'd63; wr_data = 8'h7f; cyc(1'b0, 1'b0);
        wr_en = 1'b1; wr_addr = 7'd64; wr_data = 8'd99; cyc(1'b0, 1'b0);

        // Back-to-back frames: start in the frame_done cycle
        cyc(1'b1, 1'b0);
        fpx = int'($signed(px[0]));
        lpx = fpx;
        seen = 0;
        for (int i = 0; i < 200 && seen == 0; i++) begin
            if (fd[0]) begin
                seen = 1;
                cyc(1'b1, 1'b0);
            end else begin
                cyc(1'b0, 1'b0);
                if (ov[0]) lpx = int'($signed(px[0]));
            end
        end
        check("extreme first pixel", fpx, -128);
        check("extreme last pixel", lpx, 127);
        check("b2b done seen", seen, 1);
        check("b2b restart valid", int'(ov[0]), 1);
        check("b2b restart pixel", int'($signed(px[0])), -128);
        drain(120);

        // Reset while pixel 20 is on the output aborts the frame
        cyc(1'b1, 1'b0);
        seen = 0;
        for (int i = 0; i < 100 && seen == 0; i++) begin
            if (ov[0] && $signed(px[0]) == $signed(mem_m[20]) && m_k[0] == 21) seen = 1;
            else cyc(1'b0, 1'b0);
        end
        check("reached pixel 20", seen, 1);
        rst = 1'b1; cyc(1'b0, 1'b0);
        check("abort valid low", int'(ov[0]), 0);
        check("abort busy low", int'(bz[0]), 0);
        drain(90);
        cyc(1'b1, 1'b0);
        check("restart pixel 0", int'($signed(px[0])), int'($signed(mem_m[0])));
        drain(120);

        // Randomized starts, pauses and writes (including same-cycle read/write)
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                wr_en   = 1'b1;
                wr_addr = 7'($urandom_range(0, 79));
                wr_data = 8'($urandom);
            end
            cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
        end
        drain(150);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
